// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display. It blanks at the start of
// each slot, hex-decodes the active digit and applies new content only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int DIV   = 100_000,
  parameter int BLANK = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dots,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    slot_reg, slot_next;
  logic [15:0]   sh_val_reg, sh_val_next;
  logic [3:0]    sh_dots_reg, sh_dots_next;
  logic [3:0]    sh_en_reg, sh_en_next;

  logic [3:0]    an_reg, an_next;
  logic [6:0]    seg_reg;
  logic          dp_reg;
  logic          load_ack_reg;
  logic          frame_end_reg;

  logic          capture;
  logic          drive_next;
  logic          frame_end_next;
  logic [3:0]    nib [4];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Everything below is evaluated for the *next* position so registered outputs line up with it.
  always_comb begin
    capture = (slot_reg == 2'd3) && (cnt_reg == CNT_LAST) && load;
    if (cnt_reg == CNT_LAST) begin
      cnt_next  = '0;
      slot_next = slot_reg + 2'd1;
    end else begin
      cnt_next  = cnt_reg + CW'(1);
      slot_next = slot_reg;
    end
    sh_val_next    = capture ? value    : sh_val_reg;
    sh_dots_next   = capture ? dots     : sh_dots_reg;
    sh_en_next     = capture ? digit_en : sh_en_reg;
    drive_next     = (cnt_next >= CNT_BLANK) && sh_en_next[slot_next];
    frame_end_next = (slot_next == 2'd3) && (cnt_next == CNT_LAST);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign nib[gi]     = sh_val_next[4*gi +: 4];
      assign an_next[gi] = ~(drive_next && (slot_next == 2'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg       <= '0;
      slot_reg      <= 2'd0;
      sh_val_reg    <= 16'h0000;
      sh_dots_reg   <= 4'h0;
      sh_en_reg     <= 4'hF;
      an_reg        <= 4'hF;
      seg_reg       <= 7'h7F;
      dp_reg        <= 1'b1;
      load_ack_reg  <= 1'b0;
      frame_end_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      slot_reg      <= slot_next;
      sh_val_reg    <= sh_val_next;
      sh_dots_reg   <= sh_dots_next;
      sh_en_reg     <= sh_en_next;
      an_reg        <= an_next;
      seg_reg       <= drive_next ? hex7(nib[slot_next]) : 7'h7F;
      dp_reg        <= ~(drive_next && sh_dots_next[slot_next]);
      load_ack_reg  <= capture;
      frame_end_reg <= frame_end_next;
    end
  end

  assign an        = an_reg;
  assign seg       = seg_reg;
  assign dp        = dp_reg;
  assign load_ack  = load_ack_reg;
  assign frame_end = frame_end_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (DIV=8, BLANK=2): a frame-position model checked
// every cycle, plus a table of hand-computed display points and multi-cycle corner sequences.
module tb_seg7_scan_ctrl;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dots = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_end;

  seg7_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .value(value), .dots(dots), .digit_en(digit_en),
    .load(load), .load_ack(load_ack), .an(an), .seg(seg), .dp(dp), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit hold_load = 1'b0;

  // Reference model: frame position plus the currently displayed content.
  int          m_p;
  logic [15:0] m_val;
  logic [3:0]  m_dots, m_en;
  logic        m_ack;
  logic [6:0]  hex_tab [16];
  logic [3:0]  an_seq [4];

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dts;
    logic [3:0]  en;
    int          pos;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s p=%0d actual=%0h required=%0h", name, m_p, act, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_val = 16'h0; m_dots = 4'h0; m_en = 4'hF; m_ack = 1'b0;
  endtask

  task automatic check_model();
    int slot;
    int c;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    slot = m_p / DIV;
    c    = m_p % DIV;
    ea = 4'hF; es = 7'h7F; ed = 1'b1;
    if (c >= BLANK && m_en[slot]) begin
      ea = ~(4'b0001 << slot);
      es = hex_tab[m_val[4*slot +: 4]];
      ed = ~m_dots[slot];
    end
    chk("an", 32'(an), 32'(ea));
    chk("seg", 32'(seg), 32'(es));
    chk("dp", 32'(dp), 32'(ed));
    chk("frame_end", 32'(frame_end), 32'(m_p == FRAME - 1));
    chk("load_ack", 32'(load_ack), 32'(m_ack));
  endtask

  // Advance one clock: model the edge with the inputs the DUT is about to sample, then compare.
  task automatic step();
    if (m_p == FRAME - 1 && load) begin
      m_val = value; m_dots = dots; m_en = digit_en; m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
    m_p = (m_p + 1) % FRAME;
    @(negedge clk);
    check_model();
    if (load_ack) begin
      $display("load_ack p=%0d val=%h dots=%b en=%b", m_p, m_val, m_dots, m_en);
      if (!hold_load) load = 1'b0;
    end
  endtask

  task automatic goto_pos(input int p);
    for (int i = 0; i < FRAME && m_p != p; i++) step();
    chk("goto_pos", 32'(m_p), 32'(p));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    bit got;
    got = 1'b0;
    value = v; dots = d; digit_en = e; load = 1'b1;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      step();
      got = load_ack;
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (got) chk("ack_pos", 32'(m_p), 32'd0);
  endtask

  initial begin
    int acks, fends, last_ack;
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    an_seq  = '{4'hE, 4'hD, 4'hB, 4'h7};
    tbl[0]  = '{16'h1A8F, 4'b0100, 4'hF,  4, 4'b1110, 7'b0001110, 1'b1};
    tbl[1]  = '{16'h1A8F, 4'b0100, 4'hF, 12, 4'b1101, 7'b0000000, 1'b1};
    tbl[2]  = '{16'h1A8F, 4'b0100, 4'hF, 20, 4'b1011, 7'b0001000, 1'b0};
    tbl[3]  = '{16'h1A8F, 4'b0100, 4'hF, 28, 4'b0111, 7'b1111001, 1'b1};
    tbl[4]  = '{16'h1A8F, 4'b0100, 4'hF,  9, 4'b1111, 7'b1111111, 1'b1};
    tbl[5]  = '{16'h1A8F, 4'b0000, 4'b0101, 12, 4'b1111, 7'b1111111, 1'b1};
    tbl[6]  = '{16'h1A8F, 4'b0000, 4'b0101, 28, 4'b1111, 7'b1111111, 1'b1};
    tbl[7]  = '{16'h1A8F, 4'b0000, 4'b0101,  4, 4'b1110, 7'b0001110, 1'b1};
    tbl[8]  = '{16'h1A8F, 4'b0000, 4'b0101, 20, 4'b1011, 7'b0001000, 1'b1};
    tbl[9]  = '{16'h2345, 4'b1000, 4'hF, 30, 4'b0111, 7'b0100100, 1'b0};
    tbl[10] = '{16'h2345, 4'b1000, 4'hF,  7, 4'b1110, 7'b0010010, 1'b1};
    tbl[11] = '{16'hC0DE, 4'b0000, 4'hF, 15, 4'b1101, 7'b0100001, 1'b1};

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_ack", 32'(load_ack), 32'd0);
    chk("rst_fe", 32'(frame_end), 32'd0);
    rst = 1'b1;
    check_model();
    step();
    chk("p1_blank_an", 32'(an), 32'hF);
    step();
    chk("p2_an", 32'(an), 32'hE);
    chk("p2_seg", 32'(seg), 32'h40);

    // Table-driven display points; the first request arrives at p=5
    goto_pos(5);
    for (int i = 0; i < 12; i++) begin
      do_load(tbl[i].val, tbl[i].dts, tbl[i].en);
      goto_pos(tbl[i].pos);
      chk("tbl_an", 32'(an), 32'(tbl[i].an));
      chk("tbl_seg", 32'(seg), 32'(tbl[i].seg));
      chk("tbl_dp", 32'(dp), 32'(tbl[i].dp));
    end

    // load held for three frames: one ack per frame, 32 cycles apart
    goto_pos(5);
    value = 16'h4321; dots = 4'b0001; digit_en = 4'hF;
    hold_load = 1'b1; load = 1'b1;
    acks = 0; fends = 0; last_ack = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (frame_end) fends++;
      if (load_ack) begin
        if (last_ack >= 0) chk("ack_spacing", 32'(i - last_ack), 32'(FRAME));
        last_ack = i;
        acks++;
      end
    end
    chk("held_acks", 32'(acks), 32'd3);
    chk("held_fends", 32'(fends), 32'd3);
    load = 1'b0; hold_load = 1'b0;

    // Wrap check over two frames with all digits enabled
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      chk("wrap_an", 32'(an), 32'((m_p % DIV < BLANK) ? 4'hF : an_seq[m_p / DIV]));
    end

    // Asynchronous reset at p=20 with a request pending
    goto_pos(20);
    hold_load = 1'b1; load = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(dp), 32'd1);
    chk("arst_ack", 32'(load_ack), 32'd0);
    chk("arst_fe", 32'(frame_end), 32'd0);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk("arst_hold_ack", 32'(load_ack), 32'd0);
    end
    load = 1'b0; hold_load = 1'b0;
    model_reset();
    rst = 1'b1;
    check_model();
    goto_pos(2);
    chk("post_rst_an", 32'(an), 32'hE);
    chk("post_rst_seg", 32'(seg), 32'h40);
    for (int i = 0; i < FRAME; i++) step();

    // Random traffic: inputs and load toggle freely, the model decides what gets captured
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        value = 16'($urandom);
        dots = 4'($urandom_range(0, 15));
        digit_en = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 5) == 0) load = ~load;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scheduler for the Basys3 4-digit 7-segment display. It rotates one active-low anode through four digit slots and inserts a blanking interval at the start of each slot to suppress ghosting. It hex-decodes the digit owned by the current slot. Display content is double-buffered: a requester loads new value, dot and enable settings, and they are applied only at a frame boundary, which prevents tearing.

## Interface
Parameters:
- DIV, 100_000: clock cycles per digit slot (1 ms at 100 MHz); DIV ≥ 2
- BLANK, 1_000: cycles blanked at the start of each slot; 1 ≤ BLANK < DIV

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- value  in  16  four hex nibbles; [3:0] = digit 0 (an[0], rightmost)
- dots  in  4  decimal point per digit, 1 = lit
- digit_en  in  4  per-digit enable, 1 = digit shown
- load  in  1  level request to apply value/dots/digit_en; held stable until load_ack
- load_ack  out  1  one-cycle pulse: request captured
- an  out  4  anode select, active-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_end  out  1  high in the last cycle of every frame

## Operation
- State: prescaler cnt (0..DIV-1), slot (0..3), shadow registers sh_val[15:0], sh_dots[3:0], sh_en[3:0].
- Position p = slot*DIV + cnt; a frame is 4*DIV cycles. cnt wraps DIV-1→0 with slot+1; slot wraps 3→0.
- Blank phase (cnt < BLANK): an=1111, seg=7'h7F, dp=1.
- Drive phase (cnt ≥ BLANK): if sh_en[slot], an = ~(1<<slot), seg = decode(sh_val[4*slot+:4]), dp = ~sh_dots[slot]. Otherwise the blank values are driven.
- Decode samples (active-low): 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110; full standard hex 0–F.
- Frame end is the cycle with slot==3 and cnt==DIV-1. On that cycle's closing edge, if load==1, the shadows capture the inputs and load_ack=1 for the following cycle only (p=0).
- If load is still high after the ack, the next capture happens at the next frame end. This gives at most one ack per frame.
- Requester rule: deassert load in the cycle after seeing load_ack.
- load is ignored outside frame end; no state is kept for a load that drops early.
- Reset values: cnt=0, slot=0, sh_val=0, sh_dots=0, sh_en=1111, an=1111, seg=7F, dp=1, load_ack=0, frame_end=0.
- Reset mid-operation: all outputs and state go to reset values immediately (asynchronous). A pending request is dropped and no ack is issued.

## Timing
- All outputs are registered and computed from next-state, so at position p the outputs reflect p exactly, with no extra lag.
- First cycle after reset release is p=0, inside the blank phase.
- Shadow update at a frame boundary becomes visible from p=0. Because BLANK ≥ 1, no slot is ever half-old/half-new.
- frame_end is high for exactly one cycle every 4*DIV cycles, at p=4*DIV-1.
- load-to-ack latency: from 1 up to 4*DIV cycles, depending on frame phase.

## Test plan
DIV=8, BLANK=2 (frame = 32 cycles):
- Reset: rst low → an=1111, seg=7F, dp=1, load_ack=0, frame_end=0. After release, p=0..1 are blank; p=2..7 give an=1110, seg=1000000.
- Load value=16'h1A8F, dots=0100, digit_en=1111 at p=5:
  - Outputs stay at the old content through p=31; load_ack pulses only at the next p=0.
  - Slot 0 shows F (0001110), slot 1 shows 8 (0000000), slot 2 shows A (0001000) with dp=0, slot 3 shows 1 (an=0111, seg=1111001).
- digit_en=0101 loaded → for the whole of slots 1 and 3, an=1111 and seg=7F; slots 0 and 2 are driven normally.
- load held high for 3 frames → exactly 3 load_ack pulses, 32 cycles apart, each at p=0. frame_end is high only at p=31, 63, 95.
- rst asserted at p=20 with load high and frame end pending → outputs go to reset values within the same cycle and no load_ack follows. After release, the display shows 0000, all digits enabled.
- Wrap check over 2 frames: the an sequence per slot is 1110, 1101, 1011, 0111, each preceded by exactly 2 blank cycles.
